instr_mem_loader: RTL and testbench

Upstream feeder for the instruction-fetch stage's instruction memory write port. It assembles a byte stream from the debug UART receiver into 32-bit instruction words and issues one write strobe per word at sequential word addresses. Loading ends on a programmable halt word or when memory is full. o_busy holds the pipeline in stall/reset while a program is being loaded.

---
 rtl/instr_mem_loader_if.sv | 29 ++
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction memory loader.
// The slave modport is the loader's view; the master modport is the feeder/consumer side.
interface instr_mem_loader_if #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned MEM_DEPTH = 256
);
    localparam int unsigned CNT_W = $clog2(MEM_DEPTH) + 1;

    logic             i_start;
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             o_wr_en;
    logic [NBITS-1:0] o_wr_data;
    logic [NBITS-1:0] o_wr_addr;
    logic [CNT_W-1:0] o_word_count;
    logic             o_busy;
    logic             o_done;
    logic             o_overflow;

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_wr_en, o_wr_data, o_wr_addr, o_word_count, o_busy, o_done, o_overflow
    );

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_wr_en, o_wr_data, o_wr_addr, o_word_count, o_busy, o_done, o_overflow
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles big-endian UART bytes into instruction words and writes them to sequential
// word addresses until the halt word is written or the memory is full.
module instr_mem_loader #(
    parameter int unsigned      NBITS     = 32,
    parameter int unsigned      MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    instr_mem_loader_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(MEM_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q,    state_d;
    logic [NBITS-1:0] shift_q,    shift_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             wr_en_q,    wr_en_d;
    logic [NBITS-1:0] wr_data_q,  wr_data_d;
    logic [NBITS-1:0] wr_addr_q,  wr_addr_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             overflow_q, overflow_d;

    // State and registered outputs; reset discards any partial word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state; the write strobe is launched together with the transition into WRITE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        overflow_d = overflow_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: ;
            RECV: begin
                if (bus.i_rx_valid) begin
                    shift_d = {shift_q[NBITS-9:0], bus.i_rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = WRITE;
                        byte_cnt_d = 2'd0;
                        wr_en_d    = 1'b1;
                        wr_data_d  = {shift_q[NBITS-9:0], bus.i_rx_data};
                        wr_addr_d  = NBITS'(word_cnt_q) << 2;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (wr_data_q == HALT_WORD) begin
                    state_d    = DONE;
                    overflow_d = 1'b0;
                end else if (word_cnt_q + CNT_W'(1) == CNT_W'(MEM_DEPTH)) begin
                    state_d    = DONE;
                    overflow_d = 1'b1;
                end else begin
                    state_d = RECV;
                    // A byte arriving during the write starts the next word.
                    if (bus.i_rx_valid) begin
                        shift_d    = {shift_q[NBITS-9:0], bus.i_rx_data};
                        byte_cnt_d = 2'd1;
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // Start overrides everything in every state; a write already in flight still completes.
        if (bus.i_start) begin
            state_d    = RECV;
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            overflow_d = 1'b0;
            wr_en_d    = 1'b0;
            wr_data_d  = wr_data_q;
            wr_addr_d  = wr_addr_q;
        end

        busy_d = (state_d == RECV) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_data    = wr_data_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_word_count = word_cnt_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_overflow   = overflow_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a table of per-cycle vectors on a 256-deep instance
// plus hand sequences for reset, async reset mid-word and memory-full on a 4-deep instance.
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic       rx_valid;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_mem_loader_if #(.NBITS(32), .MEM_DEPTH(256)) bus_a ();
    instr_mem_loader_if #(.NBITS(32), .MEM_DEPTH(4))   bus_b ();

    assign bus_a.i_start    = start_a;
    assign bus_a.i_rx_valid = rx_valid;
    assign bus_a.i_rx_data  = rx_data;
    assign bus_b.i_start    = start_b;
    assign bus_b.i_rx_valid = rx_valid;
    assign bus_b.i_rx_data  = rx_data;

    instr_mem_loader #(.NBITS(32), .MEM_DEPTH(256), .HALT_WORD(32'hFFFF_FFFF)) dut_a (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus_a.slave)
    );

    instr_mem_loader #(.NBITS(32), .MEM_DEPTH(4), .HALT_WORD(32'hFFFF_FFFF)) dut_b (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [31:0] wd;
        logic [31:0] wa;
        logic [8:0]  cnt;
        logic        busy;
        logic        done;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs from a negedge and return at the following negedge.
    task automatic step(input logic sa, input logic sb, input logic v, input logic [7:0] d);
        start_a  = sa;
        start_b  = sb;
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
        start_a  = 1'b0;
        start_b  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic we, input logic [31:0] wd, input logic [31:0] wa,
                       input logic [8:0] cnt, input logic busy, input logic done, input logic ovf);
        vec_t t;
        t.s = s; t.v = v; t.d = d; t.we = we; t.wd = wd; t.wa = wa;
        t.cnt = cnt; t.busy = busy; t.done = done; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    task automatic check_a_all(input string tag, input vec_t t);
        check({tag, " wr_en"},  32'(bus_a.o_wr_en),      32'(t.we));
        check({tag, " wr_data"}, bus_a.o_wr_data,        t.wd);
        check({tag, " wr_addr"}, bus_a.o_wr_addr,        t.wa);
        check({tag, " count"},  32'(bus_a.o_word_count), 32'(t.cnt));
        check({tag, " busy"},   32'(bus_a.o_busy),       32'(t.busy));
        check({tag, " done"},   32'(bus_a.o_done),       32'(t.done));
        check({tag, " ovf"},    32'(bus_a.o_overflow),   32'(t.ovf));
    endtask

    initial begin
        logic [7:0] w3 [4];
        logic [7:0] tail [4];
        vec_t z;
        z = '{s:0, v:0, d:0, we:0, wd:0, wa:0, cnt:0, busy:0, done:0, ovf:0};

        // Expected outputs after the clock edge that consumes each row's inputs.
        add(1,0,8'h00, 0,32'h0,0, 0,1,0,0);
        add(0,1,8'h12, 0,32'h0,0, 0,1,0,0);
        add(0,1,8'h34, 0,32'h0,0, 0,1,0,0);
        add(0,1,8'h56, 0,32'h0,0, 0,1,0,0);
        add(0,1,8'h78, 1,32'h12345678,0, 0,1,0,0);
        add(0,0,8'h00, 0,32'h12345678,0, 1,1,0,0);
        add(0,1,8'hAA, 0,32'h12345678,0, 1,1,0,0);
        add(0,1,8'hBB, 0,32'h12345678,0, 1,1,0,0);
        add(0,1,8'hCC, 0,32'h12345678,0, 1,1,0,0);
        add(0,1,8'hDD, 1,32'hAABBCCDD,4, 1,1,0,0);
        add(0,0,8'h00, 0,32'hAABBCCDD,4, 2,1,0,0);
        add(0,1,8'hFF, 0,32'hAABBCCDD,4, 2,1,0,0);
        add(0,1,8'hFF, 0,32'hAABBCCDD,4, 2,1,0,0);
        add(0,1,8'hFF, 0,32'hAABBCCDD,4, 2,1,0,0);
        add(0,1,8'hFF, 1,32'hFFFFFFFF,8, 2,1,0,0);
        add(0,0,8'h00, 0,32'hFFFFFFFF,8, 3,0,1,0);
        add(0,1,8'h11, 0,32'hFFFFFFFF,8, 3,0,1,0);
        // Restart from DONE, then a byte during WRITE becomes byte 1 of the next word.
        add(1,0,8'h00, 0,32'hFFFFFFFF,8, 0,1,0,0);
        add(0,1,8'h01, 0,32'hFFFFFFFF,8, 0,1,0,0);
        add(0,1,8'h02, 0,32'hFFFFFFFF,8, 0,1,0,0);
        add(0,1,8'h03, 0,32'hFFFFFFFF,8, 0,1,0,0);
        add(0,1,8'h04, 1,32'h01020304,0, 0,1,0,0);
        add(0,1,8'h55, 0,32'h01020304,0, 1,1,0,0);
        add(0,1,8'h66, 0,32'h01020304,0, 1,1,0,0);
        add(0,1,8'h77, 0,32'h01020304,0, 1,1,0,0);
        add(0,1,8'h88, 1,32'h55667788,4, 1,1,0,0);
        // Start during WRITE: write completes, counters clear.
        add(1,0,8'h00, 0,32'h55667788,4, 0,1,0,0);
        // Partial word AB CD discarded by restart in RECV.
        add(0,1,8'hAB, 0,32'h55667788,4, 0,1,0,0);
        add(0,1,8'hCD, 0,32'h55667788,4, 0,1,0,0);
        add(1,0,8'h00, 0,32'h55667788,4, 0,1,0,0);
        add(0,1,8'h01, 0,32'h55667788,4, 0,1,0,0);
        add(0,1,8'h02, 0,32'h55667788,4, 0,1,0,0);
        add(0,1,8'h03, 0,32'h55667788,4, 0,1,0,0);
        add(0,1,8'h04, 1,32'h01020304,0, 0,1,0,0);
        add(0,0,8'h00, 0,32'h01020304,0, 1,1,0,0);
        // Start with a simultaneous byte: the byte is dropped.
        add(1,1,8'h99, 0,32'h01020304,0, 0,1,0,0);
        add(0,1,8'hA1, 0,32'h01020304,0, 0,1,0,0);
        add(0,1,8'hA2, 0,32'h01020304,0, 0,1,0,0);
        add(0,1,8'hA3, 0,32'h01020304,0, 0,1,0,0);
        add(0,1,8'hA4, 1,32'hA1A2A3A4,0, 0,1,0,0);
        add(0,0,8'h00, 0,32'hA1A2A3A4,0, 1,1,0,0);

        // Reset, then bytes without start are ignored.
        rst_n = 1'b0; start_a = 0; start_b = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(negedge clk);
        check_a_all("rst", z);
        rst_n = 1'b1;
        step(0,0,0,8'h00);
        check_a_all("idle", z);
        w3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(0,0,1,w3[i]);
            check("idle_nostart wr_en", 32'(bus_a.o_wr_en), 32'd0);
            check("idle_nostart busy",  32'(bus_a.o_busy),  32'd0);
        end

        foreach (vecs[i]) begin
            step(vecs[i].s, 1'b0, vecs[i].v, vecs[i].d);
            check_a_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset mid-word clears outputs without a clock edge.
        step(1,0,0,8'h00);
        step(0,0,1,8'h01);
        step(0,0,1,8'h02);
        step(0,0,1,8'h03);
        check("pre_rst busy", 32'(bus_a.o_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst busy",    32'(bus_a.o_busy),    32'd0);
        check("async_rst wr_data", bus_a.o_wr_data,      32'd0);
        check("async_rst wr_en",   32'(bus_a.o_wr_en),   32'd0);
        @(negedge clk);
        check("async_rst held wr_en", 32'(bus_a.o_wr_en), 32'd0);
        rst_n = 1'b1;
        tail = '{8'h04, 8'h05, 8'h06, 8'h07};
        for (int i = 0; i < 4; i++) begin
            step(0,0,1,tail[i]);
            check("post_rst wr_en", 32'(bus_a.o_wr_en), 32'd0);
            check("post_rst busy",  32'(bus_a.o_busy),  32'd0);
        end

        // Memory-full on the 4-deep instance.
        step(0,1,0,8'h00);
        check("b start busy", 32'(bus_b.o_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(0,0,1,8'(k + 1));
            step(0,0,1,8'hA0);
            step(0,0,1,8'hB0);
            step(0,0,1,8'hC0);
            check($sformatf("b w%0d wr_en", k),   32'(bus_b.o_wr_en), 32'd1);
            check($sformatf("b w%0d wr_data", k), bus_b.o_wr_data,    {8'(k + 1), 24'hA0B0C0});
            check($sformatf("b w%0d wr_addr", k), bus_b.o_wr_addr,    32'(k * 4));
            step(0,0,0,8'h00);
            check($sformatf("b w%0d count", k),   32'(bus_b.o_word_count), 32'(k + 1));
        end
        check("b done", 32'(bus_b.o_done),     32'd1);
        check("b ovf",  32'(bus_b.o_overflow), 32'd1);
        check("b busy", 32'(bus_b.o_busy),     32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0,0,1,8'h5A);
            check("b extra wr_en", 32'(bus_b.o_wr_en),      32'd0);
            check("b extra count", 32'(bus_b.o_word_count), 32'd4);
        end
        check("b extra done", 32'(bus_b.o_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
